// File: rtl/core_pkg.sv
// Shared fetch-side types and constants for the core.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = ~32'h3;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: sync active-low reset, load enable.
module pc_reg #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RESET_VECTOR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned word for decode and picks trap/branch/next PC.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            decode_ready_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] PC_MASK =
        XLEN'({{32{1'b1}}, ALIGN_MASK});

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic            kill;
    logic            kill_n;
    logic            valid_n;
    logic [31:0]     instr_n;
    logic [XLEN-1:0] ipc_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic            pc_load;
    logic            req;
    logic            redirect;
    logic [XLEN-1:0] target;

    assign redirect = trap_i || branch_taken_i;
    assign target   = (trap_i ? trap_vector_i : branch_target_i) & PC_MASK;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc)
    );

    always_comb begin
        state_n = state;
        kill_n  = kill;
        valid_n = instr_valid_o;
        instr_n = instr_o;
        ipc_n   = instr_pc_o;
        pc_load = 1'b0;
        pc_d    = pc + XLEN'(INSTR_BYTES);
        req     = 1'b0;
        if (redirect) begin
            pc_load = 1'b1;
            pc_d    = target;
            valid_n = 1'b0;
        end
        unique case (state)
            BOOT: state_n = REQ;
            REQ: begin
                req = !stall_i && !redirect;
                if (req && imem_ready_i) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // A redirect with the word still in flight must drop it later.
                if (redirect) begin
                    if (imem_rsp_valid_i) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        kill_n = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        instr_n = imem_rsp_data_i;
                        ipc_n   = pc;
                        valid_n = 1'b1;
                        pc_load = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_n = REQ;
                end else if (decode_ready_i && !stall_i) begin
                    valid_n = 1'b0;
                    state_n = REQ;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= BOOT;
            kill          <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
        end else begin
            state         <= state_n;
            kill          <= kill_n;
            instr_valid_o <= valid_n;
            instr_o       <= instr_n;
            instr_pc_o    <= ipc_n;
        end
    end

    assign imem_req_o  = reset && req;
    assign imem_addr_o = pc;
    assign pc_o        = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an imem model and scoreboard.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] btgt = '0;
    logic        trap = 1'b0;
    logic [31:0] tvec = '0;
    logic        req;
    logic [31:0] addr;
    logic        ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        dec_ready = 1'b0;
    logic [31:0] pc;

    logic        reset2 = 1'b0;
    logic        zero2 = 1'b0;
    logic [31:0] zero32 = '0;
    logic        one2 = 1'b1;
    logic        req2;
    logic [31:0] addr2;
    logic        rsp_valid2 = 1'b0;
    logic [31:0] rsp_data2 = '0;
    logic        ivalid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic [31:0] pc2;

    fetch_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall),
        .branch_taken_i   (branch),
        .branch_target_i  (btgt),
        .trap_i           (trap),
        .trap_vector_i    (tvec),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_ready_i     (ready),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (ivalid),
        .instr_o          (instr),
        .instr_pc_o       (ipc),
        .decode_ready_i   (dec_ready),
        .pc_o             (pc)
    );

    fetch_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'hFFFF_FFFC)
    ) dut2 (
        .clk              (clk),
        .reset            (reset2),
        .stall_i          (zero2),
        .branch_taken_i   (zero2),
        .branch_target_i  (zero32),
        .trap_i           (zero2),
        .trap_vector_i    (zero32),
        .imem_req_o       (req2),
        .imem_addr_o      (addr2),
        .imem_ready_i     (one2),
        .imem_rsp_valid_i (rsp_valid2),
        .imem_rsp_data_i  (rsp_data2),
        .instr_valid_o    (ivalid2),
        .instr_o          (instr2),
        .instr_pc_o       (ipc2),
        .decode_ready_i   (one2),
        .pc_o             (pc2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h13 + (a << 5);
    endfunction

    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // imem model for dut: response lat cycles after acceptance
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    always begin
        @(negedge clk);
        #3;
        rsp_valid = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem(paddr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (req && ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = addr;
            end
        end
    end

    logic        acc2 = 1'b0;
    logic [31:0] paddr2 = '0;

    always begin
        @(negedge clk);
        #3;
        rsp_valid2 = acc2;
        rsp_data2  = mem(paddr2);
        acc2       = reset2 && req2;
        paddr2     = addr2;
    end

    // Scoreboard monitor: each new buffered word is popped and compared
    int   cyc = 0;
    int   rises = 0;
    int   rise_cyc[$];
    logic prev_v = 1'b0;
    logic phase3 = 1'b0;
    logic seen4 = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (ivalid && !prev_v) begin
            exp_t e;
            rises++;
            rise_cyc.push_back(cyc);
            if (phase3 && ipc == 32'h4) seen4 = 1'b1;
            total++;
            assert (q.size() != 0) passed++;
            else begin
                failed++;
                $error("FAIL sb_unexpected: got pc %h, expected none", ipc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_pc", ipc, e.pc);
                chk("sb_data", instr, e.data);
            end
        end
        prev_v = ivalid;
    end

    initial begin
        int          d0;
        int          d1;
        logic        found;
        logic [31:0] hold_instr;

        // 1: reset and BOOT cycle
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_valid", {31'b0, ivalid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", ipc, 32'h0);
        reset = 1'b1;
        #1;
        chk("boot_req", {31'b0, req}, 32'h0);
        chk("boot_pc", pc, 32'h0);
        ready     = 1'b1;
        dec_ready = 1'b1;
        q.push_back('{pc: 32'h0, data: 32'h13});
        q.push_back('{pc: 32'h4, data: 32'h93});
        q.push_back('{pc: 32'h8, data: 32'h113});
        @(negedge clk);
        #1;
        chk("req_first", {31'b0, req}, 32'h1);
        chk("addr_first", addr, 32'h0);

        // 2: sequential stream, one word every 3 cycles
        for (int i = 0; i < 40 && rises < 3; i++) @(negedge clk);
        chk("seq_count", rises, 3);
        ready = 1'b0;
        if (rise_cyc.size() >= 3) begin
            d0 = rise_cyc[1] - rise_cyc[0];
            d1 = rise_cyc[2] - rise_cyc[1];
            chk("seq_gap0", d0, 3);
            chk("seq_gap1", d1, 3);
        end

        // 3: branch while waiting on addr 4, response one cycle later
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        lat    = 2;
        ready  = 1'b1;
        phase3 = 1'b1;
        q.push_back('{pc: 32'h0, data: 32'h13});
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #4;
            found = pend && (paddr == 32'h4);
        end
        chk("br_reach4", {31'b0, found}, 32'h1);
        @(negedge clk);
        branch = 1'b1;
        btgt   = 32'h2F;
        q.push_back('{pc: 32'h2C, data: mem(32'h2C)});
        #1;
        chk("br_noreq", {31'b0, req}, 32'h0);
        @(negedge clk);
        branch = 1'b0;
        @(negedge clk);
        #1;
        chk("br_req", {31'b0, req}, 32'h1);
        chk("br_addr", addr, 32'h2C);

        // 5: stall in HOLD for 3 cycles
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            #1;
            found = ivalid;
        end
        chk("st_hold", {31'b0, found}, 32'h1);
        chk("br_no_pc4", {31'b0, seen4}, 32'h0);
        stall      = 1'b1;
        hold_instr = mem(32'h2C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("st_valid", {31'b0, ivalid}, 32'h1);
            chk("st_instr", instr, hold_instr);
            chk("st_ipc", ipc, 32'h2C);
            chk("st_req", {31'b0, req}, 32'h0);
            chk("st_pc", pc, 32'h30);
        end
        stall = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        #1;
        chk("st_consumed", {31'b0, ivalid}, 32'h0);
        chk("st_req_next", {31'b0, req}, 32'h1);
        chk("st_addr_next", addr, 32'h30);

        // 4: trap wins over branch in the same cycle
        @(negedge clk);
        #1;
        chk("hold_addr", addr, 32'h30);
        trap   = 1'b1;
        tvec   = 32'h100;
        branch = 1'b1;
        btgt   = 32'h40;
        #1;
        chk("tr_noreq", {31'b0, req}, 32'h0);
        @(negedge clk);
        trap   = 1'b0;
        branch = 1'b0;
        #1;
        chk("tr_addr", addr, 32'h100);
        chk("tr_req", {31'b0, req}, 32'h1);
        @(negedge clk);
        #1;
        chk("tr_addr_stable", addr, 32'h100);
        q.push_back('{pc: 32'h100, data: mem(32'h100)});
        ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        ready = 1'b0;
        chk("sb_drained", q.size(), 32'h0);

        // 6: wrapping reset vector and reset while waiting
        @(negedge clk);
        reset2 = 1'b1;
        #1;
        chk("w_boot_req", {31'b0, req2}, 32'h0);
        chk("w_boot_pc", pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("w_addr0", addr2, 32'hFFFF_FFFC);
        chk("w_req0", {31'b0, req2}, 32'h1);
        repeat (2) @(negedge clk);
        #1;
        chk("w_valid", {31'b0, ivalid2}, 32'h1);
        chk("w_ipc", ipc2, 32'hFFFF_FFFC);
        chk("w_instr", instr2, mem(32'hFFFF_FFFC));
        @(negedge clk);
        #1;
        chk("w_addr1", addr2, 32'h0);
        chk("w_req1", {31'b0, req2}, 32'h1);
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        #1;
        chk("wr_valid", {31'b0, ivalid2}, 32'h0);
        chk("wr_pc", pc2, 32'hFFFF_FFFC);
        chk("wr_req", {31'b0, req2}, 32'h0);
        reset2 = 1'b1;
        #1;
        chk("wr_boot_req", {31'b0, req2}, 32'h0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
